// File: rtl/riscv_pkg.sv
// RV32I opcode constants, instruction format enumeration and opcode classification helpers
// shared by the instruction encoder.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_REG    = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} instr_fmt_t;

    // Unknown opcodes fall back to R-type packing.
    function automatic instr_fmt_t fmt_of(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: fmt_of = FMT_I;
            OP_STORE:                 fmt_of = FMT_S;
            OP_BRANCH:                fmt_of = FMT_B;
            OP_AUIPC, OP_LUI:         fmt_of = FMT_U;
            OP_JAL:                   fmt_of = FMT_J;
            default:                  fmt_of = FMT_R;
        endcase
    endfunction

    function automatic logic op_known(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: op_known = 1'b1;
            default:                            op_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I field packer (module instr_pack): decoded fields in, 32-bit word out.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o
);

    always_comb begin
        word_o = '0;
        case (fmt_of(opcode_i))
            FMT_I: begin
                word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (opcode_i == OP_IMM && (funct3_i == 3'b001 || funct3_i == 3'b101))
                    word_o[31:25] = funct7_i;
            end
            FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], opcode_i};
            FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder feeding IMEM: output register plus 1-entry skid buffer.
// Optional reject path for unsupported/misaligned bundles enabled by ENCODER_ILLEGAL_CHECK_EN.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    START_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opCode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    input  logic              load_addr,
    input  logic [ADDR_W-1:0] new_addr,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [15:0]       word_count,
    output logic              illegal
);

    logic [31:0]       word;
    logic              accept, push, xfer, bad;
    logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [31:0]       out_word_q, out_word_d, skid_word_q, skid_word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       count_q, count_d;
    logic              illegal_q, illegal_d;

    instr_pack u_pack (
        .opcode_i (opCode),
        .funct3_i (funct3),
        .funct7_i (funct7),
        .rd_i     (rd),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .imm_i    (imm),
        .word_o   (word)
    );

    always_comb begin
`ifdef ENCODER_ILLEGAL_CHECK_EN
        bad = !op_known(opCode) ||
              ((fmt_of(opCode) == FMT_B || fmt_of(opCode) == FMT_J) && imm[0]);
`else
        bad = 1'b0;
`endif
    end

    assign in_ready   = !skid_valid_q;
    assign accept     = in_valid && in_ready;
    assign push       = accept && !bad;
    assign xfer       = out_valid_q && imem_ready;
    assign imem_we    = out_valid_q;
    assign imem_wdata = out_word_q;
    assign imem_addr  = addr_q;
    assign word_count = count_q;
    assign illegal    = illegal_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        skid_valid_d = skid_valid_q;
        skid_word_d  = skid_word_q;
        addr_d       = addr_q;
        count_d      = count_q;
        illegal_d    = accept && bad;
        // Output slot free: refill from skid first, else straight from the packer.
        if (!out_valid_q || xfer) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_word_d   = skid_word_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = push;
                if (push) out_word_d = word;
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_word_d  = word;
        end
        if (load_addr && !out_valid_q)
            addr_d = new_addr;
        else if (xfer)
            addr_d = addr_q + ADDR_W'(4);
        if (xfer && count_q != '1)
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_word_q  <= '0;
            addr_q       <= START_ADDR;
            count_q      <= '0;
            illegal_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            skid_valid_q <= skid_valid_d;
            skid_word_q  <= skid_word_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            illegal_q    <= illegal_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, stall, wrap/load, reset, random traffic.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, load_addr, imem_we, imem_ready, illegal;
    logic [6:0]  opCode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, new_addr, imem_addr, imem_wdata;
    logic [15:0] word_count;

    instr_encoder #(.ADDR_W(32), .START_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opCode(opCode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .load_addr(load_addr), .new_addr(new_addr), .imem_we(imem_we),
        .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } bundle_t;

    bundle_t     pend[$];
    logic [31:0] q[$];
    logic [31:0] exp_addr;
    logic [15:0] exp_cnt;
    logic        exp_ill;
    logic        gap;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned fld(input int unsigned x, input int hi, input int lo);
        return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
    endfunction

    function automatic logic [31:0] ref_encode(input bundle_t b);
        int unsigned w, im;
        im = b.imm;
        case (b.op)
            7'd3, 7'd19, 7'd103: begin
                w = b.op + (b.rd << 7) + (b.f3 << 12) + (b.rs1 << 15) + (fld(im, 11, 0) << 20);
                if (b.op == 7'd19 && (b.f3 == 3'd1 || b.f3 == 3'd5))
                    w = (w & 32'h01FF_FFFF) + (b.f7 << 25);
            end
            7'd35: w = b.op + (fld(im, 4, 0) << 7) + (b.f3 << 12) + (b.rs1 << 15)
                       + (b.rs2 << 20) + (fld(im, 11, 5) << 25);
            7'd99: w = b.op + (fld(im, 11, 11) << 7) + (fld(im, 4, 1) << 8) + (b.f3 << 12)
                       + (b.rs1 << 15) + (b.rs2 << 20) + (fld(im, 10, 5) << 25)
                       + (fld(im, 12, 12) << 31);
            7'd23, 7'd55: w = b.op + (b.rd << 7) + (im & 32'hFFFF_F000);
            7'd111: w = b.op + (b.rd << 7) + (fld(im, 19, 12) << 12) + (fld(im, 11, 11) << 20)
                        + (fld(im, 10, 1) << 21) + (fld(im, 20, 20) << 31);
            default: w = b.op + (b.rd << 7) + (b.f3 << 12) + (b.rs1 << 15)
                         + (b.rs2 << 20) + (b.f7 << 25);
        endcase
        return w;
    endfunction

    function automatic bundle_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [4:0] rdv, input logic [4:0] r1, input logic [4:0] r2,
                                   input logic [31:0] iv);
        bundle_t b;
        b.op = op; b.f3 = f3; b.f7 = f7; b.rd = rdv; b.rs1 = r1; b.rs2 = r2; b.imm = iv;
        b.exp = ref_encode(b);
        return b;
    endfunction

    function automatic bundle_t rand_bundle();
        logic [6:0] ops [9] = '{7'd3, 7'd19, 7'd23, 7'd35, 7'd51, 7'd55, 7'd99, 7'd103, 7'd111};
        logic [6:0] op;
        if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
        else op = ops[$urandom_range(0, 8)];
        return mk(op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  $urandom);
    endfunction

    function automatic logic is_bad(input bundle_t b);
`ifdef ENCODER_ILLEGAL_CHECK_EN
        logic known;
        known = (b.op == 7'd3 || b.op == 7'd19 || b.op == 7'd23 || b.op == 7'd35 ||
                 b.op == 7'd51 || b.op == 7'd55 || b.op == 7'd99 || b.op == 7'd103 ||
                 b.op == 7'd111);
        return !known || ((b.op == 7'd99 || b.op == 7'd111) && b.imm[0]);
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle at the falling edge, check outputs against the model, advance the model.
    task automatic step();
        bundle_t b;
        logic acc, xfer, bad;
        in_valid = (pend.size() != 0) && !reset && !gap;
        if (in_valid) b = pend[0];
        else b = rand_bundle();
        opCode = b.op; funct3 = b.f3; funct7 = b.f7; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
        imm = b.imm;
        chk("in_ready", in_ready, q.size() < 2);
        chk("imem_we", imem_we, q.size() != 0);
        if (q.size() != 0) begin
            chk("imem_wdata", imem_wdata, q[0]);
            chk("imem_addr", imem_addr, exp_addr);
        end
        chk("word_count", word_count, exp_cnt);
        chk("illegal", illegal, exp_ill);
        acc  = in_valid && (q.size() < 2);
        xfer = (q.size() != 0) && imem_ready;
        bad  = is_bad(b);
        exp_ill = acc && bad;
        if (load_addr && q.size() == 0) exp_addr = new_addr;
        else if (xfer) exp_addr = exp_addr + 32'd4;
        if (xfer) begin
            void'(q.pop_front());
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        if (acc) begin
            void'(pend.pop_front());
            if (!bad) q.push_back(b.exp);
        end
        if (reset) begin
            q.delete();
            exp_addr = 32'h0; exp_cnt = 16'h0; exp_ill = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((pend.size() != 0 || q.size() != 0) && n < max_cycles) begin
            step();
            n++;
        end
        chk("drain_timeout", pend.size() + q.size(), 0);
    endtask

    initial begin
        bundle_t b;
        reset = 1'b1; in_valid = 1'b0; load_addr = 1'b0; new_addr = '0; imem_ready = 1'b0;
        gap = 1'b0; opCode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0;
        imm = '0;
        exp_addr = 32'h0; exp_cnt = 16'h0; exp_ill = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_wdata", imem_wdata, 32'h0);

        imem_ready = 1'b1;
        b = mk(7'd19, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);  b.exp = 32'h0050_0093; pend.push_back(b);
        drain(20);
        b = mk(7'd35, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);  b.exp = 32'h0020_A423; pend.push_back(b);
        b = mk(7'd99, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4); b.exp = 32'hFE20_8EE3; pend.push_back(b);
        b = mk(7'd55, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000); b.exp = 32'h1234_52B7; pend.push_back(b);
        b = mk(7'd111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048); b.exp = 32'h0010_00EF; pend.push_back(b);
        drain(40);

        imem_ready = 1'b0;
        repeat (3) pend.push_back(rand_bundle());
        repeat (5) step();
        imem_ready = 1'b1;
        drain(30);

        load_addr = 1'b1; new_addr = 32'hFFFF_FFFC;
        step();
        load_addr = 1'b0;
        pend.push_back(mk(7'd51, 3'd0, 7'd32, 5'd3, 5'd4, 5'd5, 32'h0));
        pend.push_back(mk(7'd19, 3'd5, 7'd32, 5'd6, 5'd7, 5'd0, 32'd3));
        drain(20);

        imem_ready = 1'b0;
        pend.push_back(rand_bundle());
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_wdata", imem_wdata, 32'h0);
        step();

`ifdef ENCODER_ILLEGAL_CHECK_EN
        imem_ready = 1'b1;
        pend.push_back(mk(7'd0, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0));
        pend.push_back(mk(7'd99, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd5));
        drain(20);
        repeat (2) step();
`endif

        repeat (200) pend.push_back(rand_bundle());
        for (int i = 0; i < 3000 && (pend.size() != 0 || q.size() != 0); i++) begin
            imem_ready = ($urandom_range(0, 3) != 0);
            gap        = ($urandom_range(0, 4) == 0);
            load_addr  = ($urandom_range(0, 15) == 0);
            new_addr   = $urandom & 32'hFFFF_FFFC;
            step();
        end
        gap = 1'b0; load_addr = 1'b0; imem_ready = 1'b1;
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
